// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers, one result bit per cycle.
// Define MD_DIVIDE_EN to include the restoring divider (DIV/DIVU); otherwise divide requests are ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ZERO_W   = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0]   ONE_P    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREP   = 2'd1,
    ST_ITER   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               op_ok_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               sgn_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH-1:0]   mq_r;
  logic [WIDTH-1:0]   acc_r;
  logic [CW-1:0]      cnt_r;
  logic               neg_res_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_raw_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fin_hi_s;
  logic [WIDTH-1:0]   fin_lo_s;
`ifdef MD_DIVIDE_EN
  logic               div_r;
  logic               neg_rem_r;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
`endif

`ifdef MD_DIVIDE_EN
  assign op_ok_s = 1'b1;
`else
  assign op_ok_s = ~MDOperation[1];
`endif

  assign accept_s = Start & (state_r == ST_IDLE) & op_ok_s;
  assign Busy     = (state_r != ST_IDLE);
  assign Done     = done_r;
  assign HI       = hi_r;
  assign LO       = lo_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_PREP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PREP: state_nxt_s = ST_ITER;
      ST_ITER: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_ITER;
        end
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand magnitudes and the per-iteration shift-add / shift-subtract terms.
  always_comb begin
    a_neg_s = sgn_r & a_r[WIDTH-1];
    b_neg_s = sgn_r & b_r[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = ~a_r + ONE_W;
    end else begin
      a_mag_s = a_r;
    end
    if (b_neg_s) begin
      b_mag_s = ~b_r + ONE_W;
    end else begin
      b_mag_s = b_r;
    end
    if (mq_r[0]) begin
      mul_sum_s = {1'b0, acc_r} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r};
    end
`ifdef MD_DIVIDE_EN
    div_shift_s = {acc_r, mq_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opnd_r};
`endif
  end

  // Sign correction of the finished magnitude result.
  always_comb begin
    prod_raw_s = {acc_r, mq_r};
    if (neg_res_r) begin
      prod_s = ~prod_raw_s + ONE_P;
    end else begin
      prod_s = prod_raw_s;
    end
    fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fin_lo_s = prod_s[WIDTH-1:0];
`ifdef MD_DIVIDE_EN
    if (div_r) begin
      if (opnd_r == ZERO_W) begin
        // Divide by zero leaves the dividend untouched in HI.
        fin_hi_s = a_r;
        fin_lo_s = {WIDTH{1'b1}};
      end else begin
        if (neg_rem_r) begin
          fin_hi_s = ~acc_r + ONE_W;
        end else begin
          fin_hi_s = acc_r;
        end
        if (neg_res_r) begin
          fin_lo_s = ~mq_r + ONE_W;
        end else begin
          fin_lo_s = mq_r;
        end
      end
    end else begin
      fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r       <= ZERO_W;
      b_r       <= ZERO_W;
      sgn_r     <= 1'b0;
      opnd_r    <= ZERO_W;
      mq_r      <= ZERO_W;
      acc_r     <= ZERO_W;
      cnt_r     <= CNT_ZERO;
      neg_res_r <= 1'b0;
`ifdef MD_DIVIDE_EN
      div_r     <= 1'b0;
      neg_rem_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r   <= A;
            b_r   <= B;
            sgn_r <= ~MDOperation[0];
`ifdef MD_DIVIDE_EN
            div_r <= MDOperation[1];
`endif
          end
        end
        ST_PREP: begin
          // Multiplier / dividend sits in mq_r, multiplicand / divisor in opnd_r.
          opnd_r    <= b_mag_s;
          mq_r      <= a_mag_s;
          acc_r     <= ZERO_W;
          cnt_r     <= CNT_LAST;
          neg_res_r <= a_neg_s ^ b_neg_s;
`ifdef MD_DIVIDE_EN
          neg_rem_r <= a_neg_s;
`endif
        end
        ST_ITER: begin
          cnt_r <= cnt_r - CNT_ONE;
`ifdef MD_DIVIDE_EN
          if (div_r) begin
            if (!div_trial_s[WIDTH]) begin
              acc_r <= div_trial_s[WIDTH-1:0];
              mq_r  <= {mq_r[WIDTH-2:0], 1'b1};
            end else begin
              acc_r <= div_shift_s[WIDTH-1:0];
              mq_r  <= {mq_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_r <= mul_sum_s[WIDTH:1];
            mq_r  <= {mul_sum_s[0], mq_r[WIDTH-1:1]};
          end
`else
          acc_r <= mul_sum_s[WIDTH:1];
          mq_r  <= {mul_sum_s[0], mq_r[WIDTH-1:1]};
`endif
        end
        ST_FINISH: begin
          cnt_r <= CNT_ZERO;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // HI/LO registers and the Done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_r   <= ZERO_W;
      lo_r   <= ZERO_W;
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == ST_FINISH);
      if (state_r == ST_FINISH) begin
        hi_r <= fin_hi_s;
        lo_r <= fin_lo_s;
      end else if (state_r == ST_IDLE) begin
        if (HiWrite) begin
          hi_r <= WriteData;
        end
        if (LoWrite) begin
          lo_r <= WriteData;
        end
      end
    end
  end

endmodule
